// File: rtl/score_text_writer.sv
// Converts a 16-bit score to decimal with serial double-dabble and writes
// the 11-character string "SCORE ddddd" into the character buffer.
module score_text_writer #(
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 7,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       score,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] shreg;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  bitcnt;
  logic [3:0]  idx;
  logic [6:0]  char_sel;
  logic [3:0]  blank;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] digit_char(input logic [3:0] d, input logic is_blank);
    return is_blank ? 7'h20 : 7'h30 + {3'b000, d};
  endfunction

  // Double-dabble correction applied before each shift
  always_comb begin
    bcd_adj = {add3(bcd[19:16]), add3(bcd[15:12]), add3(bcd[11:8]),
               add3(bcd[7:4]), add3(bcd[3:0])};
  end

  // Leading-zero suppression; the units digit is never blanked
  always_comb begin
    blank = 4'b0000;
    if (BLANK_ZEROS) begin
      blank[3] = (bcd[19:16] == 4'd0);
      blank[2] = blank[3] && (bcd[15:12] == 4'd0);
      blank[1] = blank[2] && (bcd[11:8] == 4'd0);
      blank[0] = blank[1] && (bcd[7:4] == 4'd0);
    end else begin
      blank = 4'b0000;
    end
  end

  always_comb begin
    char_sel = 7'h20;
    case (idx)
      4'd0:    char_sel = 7'h53;
      4'd1:    char_sel = 7'h43;
      4'd2:    char_sel = 7'h4F;
      4'd3:    char_sel = 7'h52;
      4'd4:    char_sel = 7'h45;
      4'd5:    char_sel = 7'h20;
      4'd6:    char_sel = digit_char(bcd[19:16], blank[3]);
      4'd7:    char_sel = digit_char(bcd[15:12], blank[2]);
      4'd8:    char_sel = digit_char(bcd[11:8], blank[1]);
      4'd9:    char_sel = digit_char(bcd[7:4], blank[0]);
      4'd10:   char_sel = digit_char(bcd[3:0], 1'b0);
      default: char_sel = 7'h20;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_CONVERT;
        else       state_next = S_IDLE;
      end
      S_CONVERT: begin
        if (bitcnt == 4'd15) state_next = S_WRITE;
        else                 state_next = S_CONVERT;
      end
      S_WRITE: begin
        if (wr_ready && (idx == 4'd10)) state_next = S_FINISH;
        else                            state_next = S_WRITE;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      shreg  <= 16'd0;
      bcd    <= 20'd0;
      bitcnt <= 4'd0;
      idx    <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg  <= score;
            bcd    <= 20'd0;
            bitcnt <= 4'd0;
          end
        end
        S_CONVERT: begin
          {bcd, shreg} <= {bcd_adj[18:0], shreg, 1'b0};
          bitcnt       <= bitcnt + 4'd1;
          if (bitcnt == 4'd15) idx <= 4'd0;
        end
        S_WRITE: begin
          if (wr_ready) idx <= idx + 4'd1;
        end
        S_FINISH: idx <= 4'd0;
        default:  idx <= 4'd0;
      endcase
    end
  end

  // Outputs depend only on registered state and idx, never on wr_ready/start
  assign wr_en   = (state == S_WRITE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FINISH);
  assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
  assign wr_data = (state == S_WRITE) ? char_sel : 7'h00;

endmodule
